// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AE_LEVEL = 2;
    localparam bit DEF_BYPASS   = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Almost-full defaults to two entries short of a full memory.
    function automatic int def_af_level(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 1 << DEF_ADDR_W,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Show-ahead synchronous FIFO with wrap-bit pointers, almost flags, sticky
// error flags and optional empty-FIFO cut-through.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = def_af_level(ADDR_W),
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    parameter bit BYPASS   = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wEn,
    input  logic [WIDTH-1:0]  dIn,
    input  logic              rEn,
    output logic [WIDTH-1:0]  dOut,
    output logic              full,
    output logic              empty,
    output logic              almostFull,
    output logic              almostEmpty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W+1)'(AE_LEVEL);

    generate
        if (ADDR_W < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
            $error("sync_fifo_param: illegal parameters ADDR_W=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
                   ADDR_W, AF_LEVEL, AE_LEVEL);
        end
    endgenerate

    logic [ADDR_W:0]  wptr_reg, wptr_next;
    logic [ADDR_W:0]  rptr_reg, rptr_next;
    logic             ovf_reg, ovf_next;
    logic             udf_reg, udf_next;
    logic             bypass_hit, rd_ok, wr_ok, mem_we;
    logic [WIDTH-1:0] mem_rdata;

    assign empty       = (wptr_reg == rptr_reg);
    assign full        = (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]) &&
                         (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]);
    assign count       = wptr_reg - rptr_reg;
    assign almostFull  = (count >= AF_CNT);
    assign almostEmpty = (count <= AE_CNT);
    assign overflow    = ovf_reg;
    assign underflow   = udf_reg;

    // A cut-through transfer consumes the write, so neither pointer moves.
    always_comb begin
        bypass_hit = BYPASS && empty && rEn && wEn;
        rd_ok      = rEn && !empty;
        wr_ok      = wEn && (!full || rEn) && !bypass_hit;
        mem_we     = wr_ok && !clr;
    end

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        ovf_next  = ovf_reg || (wEn && full && !rEn);
        udf_next  = udf_reg || (rEn && empty && !(BYPASS && wEn));
        if (clr) begin
            wptr_next = '0;
            rptr_next = '0;
            ovf_next  = 1'b0;
            udf_next  = 1'b0;
        end else begin
            if (wr_ok) wptr_next = wptr_reg + PTR_ONE;
            if (rd_ok) rptr_next = rptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            ovf_reg  <= 1'b0;
            udf_reg  <= 1'b0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            ovf_reg  <= ovf_next;
            udf_reg  <= udf_next;
        end
    end

    always_comb begin
        dOut = '0;
        if (bypass_hit)  dOut = dIn;
        else if (!empty) dOut = mem_rdata;
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_reg[ADDR_W-1:0]),
        .wdata (dIn),
        .raddr (rptr_reg[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule
